axi_burst_beat_checker: RTL
===========================

Name: axi_burst_beat_checker

Overview:
- Synthesizable bus monitor that sits on the same AXI4 interface as the payload-hold checker, alongside it as a second consumer of the bus.
- Tracks burst lengths from AW/AR, counts W/R beats and B responses, and flags LAST-placement and count violations as registered error pulses plus sticky flags.
- Ports are observation-only; the block never drives the bus.
- All IDs are treated as a single in-order stream. The block does not support out-of-order completion.

Parameters:
- LEN_FIFO_DEPTH, 8: depth of each length FIFO (AW len, AR len, completed-W beat count); power of 2, minimum 2.
- CNT_WIDTH, 16: width of the outstanding and completed counters.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- aw_valid, aw_ready  input  1 each  write-address handshake
- aw_len  input  8  write burst length minus 1
- w_valid, w_ready, w_last  input  1 each  write-data handshake and last flag
- b_valid, b_ready  input  1 each  write-response handshake
- ar_valid, ar_ready  input  1 each  read-address handshake
- ar_len  input  8  read burst length minus 1
- r_valid, r_ready, r_last  input  1 each  read-data handshake and last flag
- err_wlen  output  1  pulse: completed W burst beat count != paired aw_len+1
- err_wlast_missing  output  1  pulse: 256th W beat of a burst without w_last
- err_rlast_early  output  1  pulse: r_last on beat < ar_len+1
- err_rlast_missing  output  1  pulse: beat ar_len+1 without r_last
- err_r_unexpected  output  1  pulse: R beat while AR FIFO empty
- err_b_unexpected  output  1  pulse: B handshake with zero completed writes
- err_fifo_ovf  output  1  pulse: push into any full length FIFO
- err_sticky  output  1  OR of all pulses since reset
- wr_outstanding  output  CNT_WIDTH  paired writes awaiting B
- rd_outstanding  output  CNT_WIDTH  AR accepted with R burst not finished
- wr_done_cnt, rd_done_cnt  output  CNT_WIDTH  completed write (B) and read (r_last) bursts

Behaviour:
- Handshake definition: a transfer occurs when valid & ready are both high at a rising edge of clk.
- Reset: rst asynchronously clears all FIFOs, beat counters, counters and pulses. Every output resets to 0. An in-flight burst at reset is discarded.
- Error pulse timing: each err_* pulse is registered, high exactly one cycle, in the cycle after the offending handshake or pairing.
- Multiple errors in the same cycle assert simultaneously.
- AW path:
  - On AW handshake, push aw_len into the AW FIFO.
- W path:
  - A W beat counter (9 bits) counts W handshakes.
  - On the w_last beat, push count+1 (range 1..256) into the WC FIFO and clear the counter.
  - If the counter reaches 256 without w_last, assert err_wlast_missing, push 256, and clear the counter.
  - W data may precede AW; this is legal.
- Pairing (combinational from the FIFO heads, at most one pair per cycle):
  - When both the AW FIFO and the WC FIFO are non-empty, pop both.
  - If wc != aw_len+1, assert err_wlen.
  - In both cases, increment wr_outstanding.
- B path:
  - On B handshake with wr_outstanding == 0: assert err_b_unexpected; counters unchanged.
  - Otherwise: decrement wr_outstanding and increment wr_done_cnt.
  - Pairing and B in the same cycle: net outstanding change is 0. The B check uses the pre-update value.
- AR path:
  - On AR handshake, push ar_len into the AR FIFO and increment rd_outstanding.
- R path:
  - If an R beat arrives while the AR FIFO is empty (and no push occurs the same cycle): assert err_r_unexpected and ignore the beat.
  - Otherwise, the beat counter is compared with the AR FIFO head.
  - r_last with beat < len+1: assert err_rlast_early.
  - Beat == len+1 without r_last: assert err_rlast_missing.
  - Either way, the burst terminates at that beat.
  - On termination: pop the AR FIFO, clear the beat counter, decrement rd_outstanding, increment rd_done_cnt.
  - AR push to an empty FIFO and the first R beat in the same cycle: the R beat uses the pushed len (bypass).
- FIFOs:
  - Push to a full FIFO is dropped and asserts err_fifo_ovf.
  - Simultaneous push and pop on a full FIFO is legal and not an overflow.
  - Pointers wrap modulo LEN_FIFO_DEPTH.
- Counters:
  - All counters wrap modulo 2^CNT_WIDTH.
  - Decrement at 0 never occurs: it is guarded by the err_b_unexpected rule.
- err_sticky clears only on rst.

Test Plan:
- AW len=3, then 4 W beats with w_last on beat 4, then B → no errors; wr_outstanding 0→1→0; wr_done_cnt=1.
- 4 W beats (last on 4) sent before AW len=3 → pairing after the AW handshake; no error.
- AW len=3 with w_last on beat 2 → err_wlen pulse one cycle after pairing; err_sticky=1 and stays high.
- AR len=7 with r_last on beat 5 → err_rlast_early; a following AR len=0 with a single r_last beat → no error; rd_done_cnt=2.
- B handshake after reset with no writes → err_b_unexpected; wr_done_cnt stays 0.
- 9 AW handshakes with no W (DEPTH=8) → err_fifo_ovf on the 9th; asserting rst mid-burst → all outputs 0 immediately.

Source files
------------

// File: rtl/axi_burst_beat_checker.sv
// AXI4 burst beat monitor: pairs AW lengths with completed W bursts, checks R LAST
// placement, and tracks outstanding/completed bursts. Purely observes the bus.

module axi_bbc_len_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             ovf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             full_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == '0);
    assign full_s    = (count_r == CW'(DEPTH));
    assign head      = mem_r[rd_ptr_r];
    assign do_pop_s  = pop && !empty;
    // a same-cycle pop frees a slot, so a push into a full FIFO still lands
    assign do_push_s = push && (!full_s || do_pop_s);
    assign ovf       = push && !do_push_s;

    // pointer and occupancy tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // length storage; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end
endmodule

module axi_burst_beat_checker #(
    parameter int LEN_FIFO_DEPTH = 8,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 aw_valid,
    input  logic                 aw_ready,
    input  logic [7:0]           aw_len,
    input  logic                 w_valid,
    input  logic                 w_ready,
    input  logic                 w_last,
    input  logic                 b_valid,
    input  logic                 b_ready,
    input  logic                 ar_valid,
    input  logic                 ar_ready,
    input  logic [7:0]           ar_len,
    input  logic                 r_valid,
    input  logic                 r_ready,
    input  logic                 r_last,
    output logic                 err_wlen,
    output logic                 err_wlast_missing,
    output logic                 err_rlast_early,
    output logic                 err_rlast_missing,
    output logic                 err_r_unexpected,
    output logic                 err_b_unexpected,
    output logic                 err_fifo_ovf,
    output logic                 err_sticky,
    output logic [CNT_WIDTH-1:0] wr_outstanding,
    output logic [CNT_WIDTH-1:0] rd_outstanding,
    output logic [CNT_WIDTH-1:0] wr_done_cnt,
    output logic [CNT_WIDTH-1:0] rd_done_cnt
);
    logic       aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
    logic [8:0] wbeat_r, w_next_s;
    logic [8:0] rbeat_r, r_next_s, r_target_s;
    logic       wc_push_s, wlast_missing_s;
    logic [7:0] aw_head_s, ar_head_s, r_len_s;
    logic [8:0] wc_head_s;
    logic       aw_empty_s, wc_empty_s, ar_empty_s;
    logic       aw_ovf_s, wc_ovf_s, ar_ovf_s;
    logic       pair_s, wlen_bad_s, b_unexp_s, b_ok_s;
    logic       bypass_s, r_unexp_s, r_act_s, r_early_s, r_missing_s, r_term_s;
    logic       ar_push_s, ar_pop_s, ar_inc_s, ovf_any_s, err_any_s;

    assign aw_hs_s = aw_valid && aw_ready;
    assign w_hs_s  = w_valid && w_ready;
    assign b_hs_s  = b_valid && b_ready;
    assign ar_hs_s = ar_valid && ar_ready;
    assign r_hs_s  = r_valid && r_ready;

    assign w_next_s        = wbeat_r + 9'd1;
    assign wc_push_s       = w_hs_s && (w_last || (w_next_s == 9'd256));
    assign wlast_missing_s = w_hs_s && !w_last && (w_next_s == 9'd256);

    assign pair_s     = !aw_empty_s && !wc_empty_s;
    assign wlen_bad_s = pair_s && (wc_head_s != ({1'b0, aw_head_s} + 9'd1));
    // B legality is judged against the count before this cycle's pairing
    assign b_unexp_s  = b_hs_s && (wr_outstanding == '0);
    assign b_ok_s     = b_hs_s && !b_unexp_s;

    assign bypass_s    = ar_empty_s && ar_hs_s;
    assign r_len_s     = ar_empty_s ? ar_len : ar_head_s;
    assign r_unexp_s   = r_hs_s && ar_empty_s && !ar_hs_s;
    assign r_act_s     = r_hs_s && !r_unexp_s;
    assign r_next_s    = rbeat_r + 9'd1;
    assign r_target_s  = {1'b0, r_len_s} + 9'd1;
    assign r_early_s   = r_act_s && r_last && (r_next_s < r_target_s);
    assign r_missing_s = r_act_s && !r_last && (r_next_s == r_target_s);
    assign r_term_s    = r_act_s && (r_last || (r_next_s == r_target_s));
    // a bypassed length that terminates in the same cycle never enters the FIFO
    assign ar_push_s   = ar_hs_s && !(bypass_s && r_term_s);
    assign ar_pop_s    = r_term_s && !bypass_s;
    assign ar_inc_s    = ar_hs_s && !ar_ovf_s;

    assign ovf_any_s = aw_ovf_s || wc_ovf_s || ar_ovf_s;
    assign err_any_s = wlen_bad_s || wlast_missing_s || r_early_s || r_missing_s ||
                       r_unexp_s || b_unexp_s || ovf_any_s;

    axi_bbc_len_fifo #(.WIDTH(8), .DEPTH(LEN_FIFO_DEPTH)) u_aw_fifo (
        .clk(clk), .rst(rst), .push(aw_hs_s), .pop(pair_s), .din(aw_len),
        .head(aw_head_s), .empty(aw_empty_s), .ovf(aw_ovf_s)
    );

    axi_bbc_len_fifo #(.WIDTH(9), .DEPTH(LEN_FIFO_DEPTH)) u_wc_fifo (
        .clk(clk), .rst(rst), .push(wc_push_s), .pop(pair_s), .din(w_next_s),
        .head(wc_head_s), .empty(wc_empty_s), .ovf(wc_ovf_s)
    );

    axi_bbc_len_fifo #(.WIDTH(8), .DEPTH(LEN_FIFO_DEPTH)) u_ar_fifo (
        .clk(clk), .rst(rst), .push(ar_push_s), .pop(ar_pop_s), .din(ar_len),
        .head(ar_head_s), .empty(ar_empty_s), .ovf(ar_ovf_s)
    );

    // beat counters, error pulses, sticky flag and burst counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbeat_r           <= '0;
            rbeat_r           <= '0;
            err_wlen          <= 1'b0;
            err_wlast_missing <= 1'b0;
            err_rlast_early   <= 1'b0;
            err_rlast_missing <= 1'b0;
            err_r_unexpected  <= 1'b0;
            err_b_unexpected  <= 1'b0;
            err_fifo_ovf      <= 1'b0;
            err_sticky        <= 1'b0;
            wr_outstanding    <= '0;
            rd_outstanding    <= '0;
            wr_done_cnt       <= '0;
            rd_done_cnt       <= '0;
        end else begin
            if (wc_push_s) begin
                wbeat_r <= '0;
            end else if (w_hs_s) begin
                wbeat_r <= w_next_s;
            end else begin
                wbeat_r <= wbeat_r;
            end
            if (r_term_s) begin
                rbeat_r <= '0;
            end else if (r_act_s) begin
                rbeat_r <= r_next_s;
            end else begin
                rbeat_r <= rbeat_r;
            end
            err_wlen          <= wlen_bad_s;
            err_wlast_missing <= wlast_missing_s;
            err_rlast_early   <= r_early_s;
            err_rlast_missing <= r_missing_s;
            err_r_unexpected  <= r_unexp_s;
            err_b_unexpected  <= b_unexp_s;
            err_fifo_ovf      <= ovf_any_s;
            err_sticky        <= err_sticky || err_any_s;
            wr_outstanding    <= wr_outstanding + CNT_WIDTH'(pair_s) - CNT_WIDTH'(b_ok_s);
            wr_done_cnt       <= wr_done_cnt + CNT_WIDTH'(b_ok_s);
            rd_outstanding    <= rd_outstanding + CNT_WIDTH'(ar_inc_s) - CNT_WIDTH'(r_term_s);
            rd_done_cnt       <= rd_done_cnt + CNT_WIDTH'(r_term_s);
        end
    end
endmodule
